// File: rtl/relative_absolute_code.sv
// ---------------------------------------------------------------------------
// relative_absolute_code
//
// DPSK receive-side differential decoder. The relative-code stream from the
// demodulator/slicer is oversampled SPS clocks per symbol. A majority vote
// gives one decided symbol per symbol period, and that symbol is XORed with
// the previous decided symbol to recover the absolute code.
//
// Optional feature (macro RELATIVE_ABSOLUTE_ERRCNT_EN):
//   defined   -> err_cnt counts symbols whose samples were not unanimous,
//                saturating at 255, cleared only by rst.
//   undefined -> no counter is built; err_cnt is tied to 0.
//
// Parameters:
//   SPS  clock cycles per symbol (2..16)
//   CW   phase counter width, 2**CW >= SPS
//   OW   ones counter width,  2**OW >  SPS
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    decode enable; low clears phase/state synchronously
//   y        relative-code input, one sample per clk
//   x        decoded absolute-code bit, held between symbols
//   x_valid  one-cycle strobe when x updates
//   err_cnt  count of non-unanimous symbols (0 when feature disabled)
// ---------------------------------------------------------------------------
module relative_absolute_code #(
   parameter int SPS = 4,
   parameter int CW  = 4,
   parameter int OW  = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y,
   output logic       x,
   output logic       x_valid,
   output logic [7:0] err_cnt
);

   localparam logic [CW-1:0] LAST_PH = CW'(SPS - 1);
   localparam logic [CW-1:0] MID_PH  = CW'(SPS / 2);
   localparam logic [OW:0]   SPS_W   = (OW + 1)'(SPS);

   logic [CW-1:0] phase;
   logic [OW-1:0] ones;
   logic          prev;
   logic          mid;

   logic          last_phase;
   logic [OW-1:0] total;
   logic [OW:0]   total_x2;
   logic          mid_now;
   logic          sym;

   // Decision path. total includes the current sample so the decision can be
   // made on the last sample's edge without an extra cycle of latency.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block can leave it unassigned and infer a latch.
      last_phase = (phase == LAST_PH);
      total      = ones + OW'(y);
      total_x2   = {total, 1'b0};
      // When SPS == 2 the mid sample is the decision sample itself and has
      // not been registered yet, so take it straight from y.
      mid_now    = (phase == MID_PH) ? y : mid;
      sym        = mid_now;
      if (total_x2 > SPS_W) begin
         sym = 1'b1;
      end else if (total_x2 < SPS_W) begin
         sym = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase   <= '0;
         ones    <= '0;
         prev    <= 1'b0;
         mid     <= 1'b0;
         x       <= 1'b0;
         x_valid <= 1'b0;
      end else if (!start) begin
         // x holds its last value; the reference symbol restarts at 0.
         phase   <= '0;
         ones    <= '0;
         prev    <= 1'b0;
         mid     <= 1'b0;
         x_valid <= 1'b0;
      end else begin
         x_valid <= 1'b0;
         if (phase == MID_PH) begin
            mid <= y;
         end
         if (last_phase) begin
            x       <= sym ^ prev;
            prev    <= sym;
            x_valid <= 1'b1;
            ones    <= '0;
            phase   <= '0;
         end else begin
            ones    <= total;
            phase   <= phase + CW'(1);
         end
      end
   end

`ifdef RELATIVE_ABSOLUTE_ERRCNT_EN
   logic mixed;

   // Samples disagree when the count is neither all-zero nor all-one.
   always_comb begin
      mixed = (total != '0) && (total != OW'(SPS));
   end

   // start low deliberately does not clear the counter: it tracks link
   // quality across decode sessions until the next reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (start && last_phase && mixed && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`else
   assign err_cnt = 8'd0;
`endif

endmodule
